// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: one datapath micro-step per cycle.
// Optional retired-instruction counter enabled by INSTRET_CNT_EN.
module multicycle_controller #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
`ifdef INSTRET_CNT_EN
  output logic [CNT_W-1:0] instret,
`endif
  output logic             halt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JLINK,
    S_JALR, S_LUI, S_ILLEGAL, S_HALT
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_e     state_q, state_d;
  logic       op_r;
  logic       alu_ok, br_ok, br_take;
  logic [2:0] alu_sel;

  assign op_r = (op == OP_R);

  // Decode ALU operation and branch outcome from funct fields
  always_comb begin
    alu_sel = ALU_ADD;
    alu_ok  = 1'b1;
    case (funct3)
      3'b000: begin
        if (op_r && funct7 == 7'b0100000) alu_sel = ALU_SUB;
        else if (op_r && funct7 != 7'd0)  alu_ok  = 1'b0;
      end
      3'b111:  alu_sel = ALU_AND;
      3'b110:  alu_sel = ALU_OR;
      3'b010:  alu_sel = ALU_SLT;
      3'b100:  alu_sel = ALU_XOR;
      default: alu_ok  = 1'b0;
    endcase
    if (op_r && funct3 != 3'b000 && funct7 != 7'd0) alu_ok = 1'b0;
    if (!alu_ok) alu_sel = ALU_ADD;
    br_ok   = 1'b1;
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = Lt;
      3'b101:  br_take = ~Lt;
      default: br_ok   = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = alu_ok ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = br_ok ? S_FETCH : S_ILLEGAL;
      S_JAL,
      S_JALR:     state_d = S_JLINK;
      S_JLINK,
      S_LUI:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath controls; everything forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    halt       = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_sel;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_sel;
        end
        S_ALUWB:  RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = br_ok & br_take;
        end
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b01;
          ImmSrc    = IMM_J;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_JLINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_LUI: begin
          ALUSrcB    = 2'b01;
          ImmSrc     = IMM_U;
          ALUControl = ALU_PASS;
        end
        S_ILLEGAL: ;
        S_HALT:    halt = 1'b1;
        default:   ;
      endcase
    end
  end

`ifdef INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q;

  // Count each return to FETCH, i.e. one finished instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      instret_q <= '0;
    else if (state_q != S_FETCH && state_d == S_FETCH)
      instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
